regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register bank's single write port (WE/Rd/WD) among N_REQ writeback sources (ALU, load unit, vector unit).
//  Each source has a valid/ready handshake into a one-entry holding slot.
//  A round-robin arbiter picks one slot per cycle and drives a registered write to the bank.
//  The bank commits it on the following negedge.
//  Exports a pending-write scoreboard so issue logic can stall RAW hazards.
// PARAMETERS
//  N_REQ       3   number of writeback requesters (2..8)
//  INDEX_SIZE  4   register index width; bank holds 2**INDEX_SIZE registers
//  WIDTH       32  data width
// PORTS
//  clk         in   1                     clock; all state updates on posedge
//  rst         in   1                     reset, asynchronous, active-high
//  req_valid   in   N_REQ                 requester i offers a write
//  req_rd      in   N_REQ x INDEX_SIZE    destination index per requester
//  req_data    in   N_REQ x WIDTH         write data per requester
//  req_ready   out  N_REQ                 slot i accepts this cycle
//  we_o        out  1                     to bank WE
//  rd_o        out  INDEX_SIZE            to bank Rd
//  wd_o        out  WIDTH                 to bank WD
//  grant_o     out  N_REQ                 one-hot source of the current we_o (0 when idle)
//  pending_o   out  2**INDEX_SIZE         bit r=1: a write to r is held or on the bank port
// BEHAVIOUR
//  Reset (async, any time):
//   - hold_valid all 0; we_o=0, rd_o=0, wd_o=0, grant_o=0.
//   - rr pointer=0, so requester 0 has first priority.
//   - In-flight writes are discarded, never partially committed.
//  Acceptance:
//   - req_ready[i] = ~hold_valid[i] | win[i]. Combinational; no dependence on req_valid.
//   - Transfer happens on posedge when req_valid[i] & req_ready[i].
//   - rd==0 transfers complete the handshake but are dropped: never stored, never granted.
//  Arbitration (each posedge):
//   - Candidates: hold_valid.
//   - Winner: first candidate at or after rr, scanning upward with wrap N_REQ-1 -> 0.
//   - On a win: we_o<=1; rd_o/wd_o<=winner's slot; grant_o<=onehot; slot cleared; rr<=winner+1 (mod N_REQ).
//   - No candidate: we_o<=0, grant_o<=0, rd_o/wd_o hold; rr unchanged.
//   - Latency: accepted at edge k, earliest on port after edge k+1, committed at the negedge after edge k+1.
//   - Throughput: 1 write/cycle total. Each requester sustains 1 write per N_REQ cycles under full contention.
//  Simultaneous win and accept on the same slot:
//   - The old entry goes to the port; the new entry loads the slot.
//   - No bubble, no loss.
//  Ordering:
//   - In order per requester.
//   - Not guaranteed across requesters. Two sources holding the same rd commit in round-robin order.
//   - The issuer must not create that case; pending_o exists to prevent it.
//  Scoreboard:
//   - pending_o = OR over hold_valid slots of onehot(rd) | (we_o ? onehot(rd_o) : 0).
//   - Computed combinationally from registered state. Bit 0 is always 0.
//  Fairness: a continuously valid requester is granted within N_REQ cycles.
// STRUCTURE
//  Package rf_wb_pkg:
//   - typedef wb_req_t {logic [INDEX_SIZE-1:0] rd; logic [WIDTH-1:0] data;}
//   - localparam for the default N_REQ, INDEX_SIZE and WIDTH.
//  Sub-module rr_arbiter #(N): req, ptr -> one-hot win, combinational; the top owns the ptr register.
//  Top module: holding slots, output register, scoreboard OR-reduce.
// TESTING
//  1 Reset mid-traffic:
//    - Slots 0,1 valid; assert rst between edges.
//    - Outputs 0 immediately; pending_o=0; nothing written to the bank afterwards.
//  2 Single write:
//    - Req1 rd=5 data=0xDEADBEEF for 1 cycle.
//    - Next edge: we_o=1, rd_o=5, wd_o=0xDEADBEEF, grant_o=3'b010.
//    - Bank reg5 = 0xDEADBEEF after the negedge.
//  3 Contention:
//    - All 3 valid every cycle, rd=1,2,3.
//    - Grant sequence 0,1,2,0,1,2.
//    - we_o continuous; each req_ready toggles once per 3 cycles.
//  4 rd==0 drop:
//    - Req0 rd=0 data=0xFFFFFFFF.
//    - req_ready=1, we_o stays 0, pending_o[0]=0, bank reg0 stays 0.
//  5 Back-to-back same requester, others idle:
//    - Req2 streams rd=7,8,9.
//    - we_o=1 for 3 consecutive cycles, rd_o=7,8,9 with no bubble.
//  6 Scoreboard:
//    - Req0 rd=4 held while req1 wins.
//    - pending_o[4]=1 until the cycle after req0's grant ends, then 0.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types and defaults for the register-bank writeback arbiter.
// Writeback request payload plus the round-robin pointer helper.
package rf_wb_pkg;

  localparam int N_REQ_DEF      = 3;
  localparam int INDEX_SIZE_DEF = 4;
  localparam int WIDTH_DEF      = 32;

  typedef struct packed {
    logic [INDEX_SIZE_DEF-1:0] rd;
    logic [WIDTH_DEF-1:0]      data;
  } wb_req_t;

  // Pointer value that gives the requester after idx first priority.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping N-1 -> 0.
module rr_arbiter
  import rf_wb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register bank's single write port among N_REQ writeback sources via
// one-entry holding slots, a round-robin pick and a registered bank write.
module regfile_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int INDEX_SIZE = INDEX_SIZE_DEF,
  parameter int WIDTH      = WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [N_REQ-1:0][INDEX_SIZE-1:0]      req_rd,
  input  logic [N_REQ-1:0][WIDTH-1:0]           req_data,
  output logic [N_REQ-1:0]                      req_ready,
  output logic                                  we_o,
  output logic [INDEX_SIZE-1:0]                 rd_o,
  output logic [WIDTH-1:0]                      wd_o,
  output logic [N_REQ-1:0]                      grant_o,
  output logic [2**INDEX_SIZE-1:0]              pending_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic [INDEX_SIZE-1:0] rd;
    logic [WIDTH-1:0]      data;
  } slot_t;

  logic [N_REQ-1:0] hold_valid;
  logic [N_REQ-1:0] win;
  logic [N_REQ-1:0] keep;
  slot_t            hold [N_REQ];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win_idx;
  slot_t            win_slot;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req (hold_valid),
    .ptr (ptr),
    .win (win)
  );

  // A slot being drained this edge can take a new entry on the same edge.
  assign req_ready = ~hold_valid | win;

  // Writes to register 0 finish the handshake but never occupy a slot.
  always_comb begin
    keep = '0;
    for (int i = 0; i < N_REQ; i++) begin
      keep[i] = req_valid[i] & req_ready[i] & (req_rd[i] != '0);
    end
  end

  always_comb begin
    win_idx  = '0;
    win_slot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx  = PW'(i);
        win_slot = hold[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (keep[i]) begin
        hold[i] <= '{rd: req_rd[i], data: req_data[i]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= '0;
      ptr        <= '0;
      we_o       <= 1'b0;
      rd_o       <= '0;
      wd_o       <= '0;
      grant_o    <= '0;
    end else begin
      hold_valid <= (hold_valid & ~win) | keep;
      if (|hold_valid) begin
        we_o    <= 1'b1;
        rd_o    <= win_slot.rd;
        wd_o    <= win_slot.data;
        grant_o <= win;
        ptr     <= PW'(rr_next(int'(win_idx), N_REQ));
      end else begin
        we_o    <= 1'b0;
        grant_o <= '0;
      end
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (hold_valid[i]) begin
        pending_o[hold[i].rd] = 1'b1;
      end
    end
    if (we_o) begin
      pending_o[rd_o] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: accepted writes are queued per source and matched
// against each bank write; scenario tasks check grants, readiness and the scoreboard.
module tb_regfile_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int N  = N_REQ_DEF;
  localparam int IS = INDEX_SIZE_DEF;
  localparam int W  = WIDTH_DEF;
  localparam int NR = 2**IS;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            req_valid;
  logic [N-1:0][IS-1:0]    req_rd;
  logic [N-1:0][W-1:0]     req_data;
  logic [N-1:0]            req_ready;
  logic                    we_o;
  logic [IS-1:0]           rd_o;
  logic [W-1:0]            wd_o;
  logic [N-1:0]            grant_o;
  logic [NR-1:0]           pending_o;

  typedef struct {
    int      src;
    wb_req_t r;
  } exp_t;

  exp_t        sb[$];
  exp_t        acc_e;
  logic [W-1:0] bank [NR];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          mon_g;
  int          mon_hit;

  regfile_wb_arbiter #(.N_REQ(N), .INDEX_SIZE(IS), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we_o      (we_o),
    .rd_o      (rd_o),
    .wd_o      (wd_o),
    .grant_o   (grant_o),
    .pending_o (pending_o)
  );

  always #5 clk = ~clk;

  initial begin
    for (int r = 0; r < NR; r++) bank[r] = '0;
  end

  // Bank commits on the negedge following the registered write.
  always @(negedge clk) begin
    if (we_o) bank[rd_o] = wd_o;
  end

  // Record every transfer the bench expects to reach the bank.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i] && req_rd[i] != '0) begin
          acc_e.src    = i;
          acc_e.r.rd   = req_rd[i];
          acc_e.r.data = req_data[i];
          sb.push_back(acc_e);
        end
      end
    end
  end

  // Match each bank write to the oldest outstanding entry of the granted source.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if (we_o) begin
        mon_g = -1;
        for (int i = 0; i < N; i++) if (grant_o[i]) mon_g = i;
        if (!$onehot(grant_o)) begin
          n_fail++;
          $display("FAIL mon_grant_onehot: got %b, required one-hot", grant_o);
        end else begin
          mon_hit = -1;
          for (int k = 0; k < sb.size(); k++) begin
            if (mon_hit < 0 && sb[k].src == mon_g) mon_hit = k;
          end
          if (mon_hit < 0) begin
            n_fail++;
            $display("FAIL mon_unexpected_write: src %0d rd %0d data %h, required none", mon_g, rd_o, wd_o);
          end else begin
            if (rd_o !== sb[mon_hit].r.rd || wd_o !== sb[mon_hit].r.data) begin
              n_fail++;
              $display("FAIL mon_write: src %0d got rd %0d data %h, required rd %0d data %h",
                       mon_g, rd_o, wd_o, sb[mon_hit].r.rd, sb[mon_hit].r.data);
            end
            sb.delete(mon_hit);
          end
        end
      end else if (grant_o !== '0) begin
        n_fail++;
        $display("FAIL mon_idle_grant: got %b, required 000", grant_o);
      end
    end
  end

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    #1;
    n_tests++;
    if (we_o !== 1'b0 || rd_o !== '0 || wd_o !== '0 || grant_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we %b rd %0d wd %h grant %b, required all 0", we_o, rd_o, wd_o, grant_o);
    end
    n_tests++;
    if (pending_o !== '0) begin
      n_fail++;
      $display("FAIL reset_pending: got %h, required 0", pending_o);
    end
    n_tests++;
    if (req_ready !== '1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 111", req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_traffic;
    @(negedge clk);
    req_valid   = 3'b011;
    req_rd[0]   = 4'd10;
    req_rd[1]   = 4'd11;
    req_data[0] = 32'h1010_1010;
    req_data[1] = 32'h1111_1111;
    @(posedge clk);
    #1;
    req_valid = '0;
    n_tests++;
    if (pending_o !== ((NR'(1) << 10) | (NR'(1) << 11))) begin
      n_fail++;
      $display("FAIL midrst_held: got pending %h, required bits 10,11", pending_o);
    end
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    n_tests++;
    if (we_o !== 1'b0 || grant_o !== '0 || pending_o !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got we %b grant %b pending %h, required 0", we_o, grant_o, pending_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (bank[10] !== '0 || bank[11] !== '0) begin
      n_fail++;
      $display("FAIL midrst_bank: got r10 %h r11 %h, required 0", bank[10], bank[11]);
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    req_valid   = 3'b010;
    req_rd[1]   = 4'd5;
    req_data[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = '0;
    n_tests++;
    if (we_o !== 1'b0 || pending_o !== (NR'(1) << 5)) begin
      n_fail++;
      $display("FAIL single_held: got we %b pending %h, required we 0 pending bit5", we_o, pending_o);
    end
    @(negedge clk);
    n_tests++;
    if (we_o !== 1'b1 || rd_o !== 4'd5 || wd_o !== 32'hDEAD_BEEF || grant_o !== 3'b010) begin
      n_fail++;
      $display("FAIL single_port: got we %b rd %0d wd %h grant %b, required 1 5 deadbeef 010",
               we_o, rd_o, wd_o, grant_o);
    end
    @(negedge clk);
    n_tests++;
    if (bank[5] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_bank: got %h, required deadbeef", bank[5]);
    end
    n_tests++;
    if (we_o !== 1'b0 || pending_o !== '0) begin
      n_fail++;
      $display("FAIL single_idle: got we %b pending %h, required 0", we_o, pending_o);
    end
  endtask

  task automatic test_contention;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < N; i++) begin
        req_rd[i]   = IS'(i + 1);
        req_data[i] = 32'hC000_0000 + 32'(i << 16) + 32'(c);
      end
      req_valid = '1;
      @(negedge clk);
      if (c == 0) begin
        n_tests++;
        if (we_o !== 1'b0 || req_ready !== 3'b001) begin
          n_fail++;
          $display("FAIL cont_first: got we %b ready %b, required 0 001", we_o, req_ready);
        end
      end else begin
        n_tests++;
        if (we_o !== 1'b1 || grant_o !== (N'(1) << ((c - 1) % N))) begin
          n_fail++;
          $display("FAIL cont_grant[%0d]: got we %b grant %b, required 1 %b",
                   c, we_o, grant_o, N'(1) << ((c - 1) % N));
        end
        n_tests++;
        if (req_ready !== (N'(1) << (c % N))) begin
          n_fail++;
          $display("FAIL cont_ready[%0d]: got %b, required %b", c, req_ready, N'(1) << (c % N));
        end
      end
    end
    req_valid = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_rd0_drop;
    @(negedge clk);
    req_valid   = 3'b001;
    req_rd[0]   = '0;
    req_data[0] = 32'hFFFF_FFFF;
    #1;
    n_tests++;
    if (req_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rd0_ready: got %b, required 1", req_ready[0]);
    end
    @(negedge clk);
    req_valid = '0;
    n_tests++;
    if (we_o !== 1'b0 || pending_o !== '0 || req_ready !== '1) begin
      n_fail++;
      $display("FAIL rd0_dropped: got we %b pending %h ready %b, required 0 0 111", we_o, pending_o, req_ready);
    end
    @(negedge clk);
    n_tests++;
    if (we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_no_write: got we %b, required 0", we_o);
    end
    @(negedge clk);
    n_tests++;
    if (bank[0] !== '0) begin
      n_fail++;
      $display("FAIL rd0_bank: got %h, required 0", bank[0]);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      req_valid   = 3'b100;
      req_rd[2]   = IS'(7 + j);
      req_data[2] = 32'hB0B0_0000 + 32'(j);
      n_tests++;
      if (req_ready[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b, required 1", j, req_ready[2]);
      end
      @(negedge clk);
      if (j >= 1) begin
        n_tests++;
        if (we_o !== 1'b1 || rd_o !== IS'(6 + j)) begin
          n_fail++;
          $display("FAIL b2b_port[%0d]: got we %b rd %0d, required 1 %0d", j, we_o, rd_o, 6 + j);
        end
      end
    end
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (we_o !== 1'b1 || rd_o !== 4'd9) begin
      n_fail++;
      $display("FAIL b2b_last: got we %b rd %0d, required 1 9", we_o, rd_o);
    end
    @(negedge clk);
    n_tests++;
    if (we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got we %b, required 0", we_o);
    end
  endtask

  task automatic test_scoreboard;
    do_reset();
    req_valid   = 3'b001;
    req_rd[0]   = 4'd12;
    req_data[0] = 32'h0000_0C0C;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    req_valid   = 3'b011;
    req_rd[0]   = 4'd4;
    req_data[0] = 32'h4444_4444;
    req_rd[1]   = 4'd13;
    req_data[1] = 32'h1313_1313;
    @(negedge clk);
    req_valid = '0;
    n_tests++;
    if (pending_o !== ((NR'(1) << 4) | (NR'(1) << 13))) begin
      n_fail++;
      $display("FAIL sb_both_held: got %h, required bits 4,13", pending_o);
    end
    @(negedge clk);
    n_tests++;
    if (grant_o !== 3'b010 || pending_o[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_req1_wins: got grant %b pending4 %b, required 010 1", grant_o, pending_o[4]);
    end
    @(negedge clk);
    n_tests++;
    if (grant_o !== 3'b001 || pending_o !== (NR'(1) << 4)) begin
      n_fail++;
      $display("FAIL sb_req0_port: got grant %b pending %h, required 001 bit4", grant_o, pending_o);
    end
    @(negedge clk);
    n_tests++;
    if (pending_o !== '0) begin
      n_fail++;
      $display("FAIL sb_cleared: got %h, required 0", pending_o);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_traffic();
    test_single();
    test_contention();
    test_rd0_drop();
    test_back_to_back();
    test_scoreboard();
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
